router_fsm: RTL and testbench

Control FSM of the 1x3 packet router. It watches the incoming byte stream's valid and address, and the three output FIFOs' empty/full and soft-reset signals. It generates one-hot-style phase strobes for the register and synchronizer blocks: header detect, first-byte load, payload load, full stall, parity load/check. It sits between the router input interface, the router register block and the synchronizer.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm.sv | 135 +++++++++++++
 tb/tb_router_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types for the 1x3 packet router control path.
// FSM state encoding and header address codes.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: header decode, load phases, full stall, parity check.
// Optional: ROUTER_FSM_SOFT_RST_EN enables soft reset from the output FIFOs.
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pktvalid,
    input  logic       parity_done,
    input  logic       srst0,
    input  logic       srst1,
    input  logic       srst2,
    input  logic       fifofull,
    input  logic       lowpktvalid,
    input  logic       fifoe0,
    input  logic       fifoe1,
    input  logic       fifoe2,
    input  logic [1:0] din,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       lfd_state,
    output logic       we_en_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] addr;
    logic       din_empty;
    logic       addr_empty;
    logic       soft_rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DECODE_ADDRESS;
            addr  <= ADDR0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && pktvalid)
                addr <= din;
        end
    end

    always_comb begin
        din_empty = 1'b0;
        case (din)
            ADDR0:   din_empty = fifoe0;
            ADDR1:   din_empty = fifoe1;
            ADDR2:   din_empty = fifoe2;
            default: din_empty = 1'b0;
        endcase
    end

    always_comb begin
        addr_empty = 1'b0;
        case (addr)
            ADDR0:   addr_empty = fifoe0;
            ADDR1:   addr_empty = fifoe1;
            ADDR2:   addr_empty = fifoe2;
            default: addr_empty = 1'b0;
        endcase
    end

`ifdef ROUTER_FSM_SOFT_RST_EN
    // Only the FIFO this packet is headed for may abort it.
    always_comb begin
        soft_rst = 1'b0;
        case (addr)
            ADDR0:   soft_rst = srst0;
            ADDR1:   soft_rst = srst1;
            ADDR2:   soft_rst = srst2;
            default: soft_rst = 1'b0;
        endcase
    end
`else
    logic unused_srst;
    assign unused_srst = ^{srst0, srst1, srst2};
    assign soft_rst    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (pktvalid && din != ADDR_INVALID)
                    state_nxt = din_empty ? LOAD_FIRST_DATA
                                          : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifofull)
                    state_nxt = FIFO_FULL_STATE;
                else if (!pktvalid)
                    state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifofull)
                    state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (lowpktvalid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_nxt = fifofull ? FIFO_FULL_STATE
                                     : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (addr_empty)
                    state_nxt = LOAD_FIRST_DATA;
            end
        endcase
        if (soft_rst)
            state_nxt = DECODE_ADDRESS;
    end

    assign detect_add  = (state == DECODE_ADDRESS);
    assign lfd_state   = (state == LOAD_FIRST_DATA);
    assign ld_state    = (state == LOAD_DATA);
    assign full_state  = (state == FIFO_FULL_STATE);
    assign laf_state   = (state == LOAD_AFTER_FULL);
    assign rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign we_en_reg   = ld_state | laf_state
                       | (state == LOAD_PARITY);
    assign busy        = !(detect_add | ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios, then random traffic
// against a phase-name reference model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pktvalid, parity_done, fifofull, lowpktvalid;
    logic       srst0, srst1, srst2;
    logic       fifoe0, fifoe1, fifoe2;
    logic [1:0] din;
    logic       detect_add, ld_state, laf_state, full_state, lfd_state;
    logic       we_en_reg, rst_int_reg, busy;

    int errors = 0;
    int checks = 0;

`ifdef ROUTER_FSM_SOFT_RST_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    string      m_ph;
    logic [1:0] m_addr;

    router_fsm dut (
        .clk(clk), .rst(rst), .pktvalid(pktvalid),
        .parity_done(parity_done),
        .srst0(srst0), .srst1(srst1), .srst2(srst2),
        .fifofull(fifofull), .lowpktvalid(lowpktvalid),
        .fifoe0(fifoe0), .fifoe1(fifoe1), .fifoe2(fifoe2),
        .din(din), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state),
        .lfd_state(lfd_state), .we_en_reg(we_en_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic empty_of(input logic [1:0] a);
        logic [2:0] e;
        e = {fifoe2, fifoe1, fifoe0};
        return (a == 2'd3) ? 1'b0 : e[a];
    endfunction

    function automatic logic srst_of(input logic [1:0] a);
        logic [2:0] s;
        s = {srst2, srst1, srst0};
        return (a == 2'd3) ? 1'b0 : s[a];
    endfunction

    // One clock of the reference model, using inputs held at the edge.
    task automatic model_advance();
        string nx;
        nx = m_ph;
        if (m_ph == "DA") begin
            if (pktvalid && din != 2'd3)
                nx = empty_of(din) ? "LFD" : "WTE";
        end else if (m_ph == "LFD") nx = "LD";
        else if (m_ph == "LD") begin
            if (fifofull) nx = "FFS";
            else if (!pktvalid) nx = "LP";
        end else if (m_ph == "FFS") begin
            if (!fifofull) nx = "LAF";
        end else if (m_ph == "LAF") begin
            nx = parity_done ? "DA" : (lowpktvalid ? "LP" : "LD");
        end else if (m_ph == "LP") nx = "CPE";
        else if (m_ph == "CPE") nx = fifofull ? "FFS" : "DA";
        else if (m_ph == "WTE") begin
            if (empty_of(m_addr)) nx = "LFD";
        end
        if (SOFT_EN && srst_of(m_addr)) nx = "DA";
        if (m_ph == "DA" && pktvalid) m_addr = din;
        m_ph = nx;
    endtask

    task automatic check(input string tag);
        logic [7:0] obs, exp;
        obs = {detect_add, lfd_state, ld_state, full_state,
               laf_state, rst_int_reg, we_en_reg, busy};
        exp = {m_ph == "DA", m_ph == "LFD", m_ph == "LD",
               m_ph == "FFS", m_ph == "LAF", m_ph == "CPE",
               m_ph == "LD" || m_ph == "LAF" || m_ph == "LP",
               !(m_ph == "DA" || m_ph == "LD")};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outputs=%b expected=%b (phase %s)",
                   tag, obs, exp, m_ph);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_advance();
        #1;
        check(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        m_ph = "DA";
        m_addr = 2'd0;
        check(tag);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pktvalid = 0; parity_done = 0; fifofull = 0; lowpktvalid = 0;
        srst0 = 0; srst1 = 0; srst2 = 0;
        fifoe0 = 0; fifoe1 = 0; fifoe2 = 0; din = 2'd0;
        m_ph = "DA";
        m_addr = 2'd0;
        #1 check("reset");
        #6 rst = 1'b1;
        step("idle_da");

        pktvalid = 1; din = 2'd1; fifoe1 = 1;
        step("lfd");
        step("ld");
        step("ld_hold");
        pktvalid = 0;
        step("lp");
        step("cpe");
        step("da_after_pkt");

        pktvalid = 1; din = 2'd0; fifoe0 = 1;
        step("lfd0");
        step("ld0");
        fifofull = 1;
        step("ffs");
        step("ffs_hold");
        fifofull = 0;
        step("laf");
        step("ld_from_laf");
        fifofull = 1;
        step("ffs2");
        fifofull = 0;
        step("laf2");
        lowpktvalid = 1;
        step("lp_from_laf");
        lowpktvalid = 0; fifofull = 1;
        step("cpe2");
        step("ffs_from_cpe");
        fifofull = 0;
        step("laf3");
        parity_done = 1;
        step("da_from_laf");
        parity_done = 0;

        pktvalid = 1; din = 2'd2; fifoe2 = 0;
        step("wte");
        step("wte_hold");
        fifoe2 = 1;
        step("lfd_from_wte");
        fifofull = 1; pktvalid = 0;
        step("ld2");
        step("ffs_wins_over_lp");
        fifofull = 0;
        step("laf4");
        parity_done = 1;
        step("da4");
        parity_done = 0;

        pktvalid = 1; din = 2'd2; fifoe2 = 0;
        step("wte2");
        pktvalid = 0; srst0 = 1;
        step("srst_other_port");
        srst0 = 0; srst2 = 1;
        step("srst_own_port");
        srst2 = 0; fifoe2 = 1;
        step("after_srst");

        async_reset("async_rst");
        pktvalid = 1; din = 2'd3;
        step("invalid_addr");
        step("invalid_addr2");
        pktvalid = 1; din = 2'd1; fifoe1 = 1;
        step("lfd_again");
        async_reset("async_rst_mid_pkt");
        pktvalid = 0;
        step("idle_after_rst");

        for (int i = 0; i < 800; i++) begin
            pktvalid    = ($urandom_range(0, 9) < 7);
            din         = 2'($urandom_range(0, 3));
            fifofull    = ($urandom_range(0, 9) < 2);
            parity_done = ($urandom_range(0, 9) < 2);
            lowpktvalid = ($urandom_range(0, 9) < 2);
            fifoe0      = ($urandom_range(0, 9) < 6);
            fifoe1      = ($urandom_range(0, 9) < 6);
            fifoe2      = ($urandom_range(0, 9) < 6);
            srst0       = ($urandom_range(0, 19) == 0);
            srst1       = ($urandom_range(0, 19) == 0);
            srst2       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0)
                async_reset("rand_async_rst");
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
